// File: rtl/audio_serial_frame_gen_pkg.sv
// Shared definitions for the audio serial frame generator:
// format encodings and clock/frame geometry helpers.
package audio_serial_frame_gen_pkg;

  typedef enum logic [1:0] {
    FMT_I2S  = 2'd0,
    FMT_LJ   = 2'd1,
    FMT_TDM  = 2'd2,
    FMT_RSVD = 2'd3
  } fmt_e;

  function automatic logic [1:0] fmt_norm(
    input logic [1:0] m
  );
    return (m == FMT_RSVD) ? FMT_I2S : m;
  endfunction

  function automatic int bck_half(
    input int os,
    input int sw,
    input int ch
  );
    return os / (2 * sw * ch);
  endfunction

  function automatic int frame_bits(
    input int sw,
    input int ch
  );
    return sw * ch;
  endfunction

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/audio_frame_shifter.sv
// Frame shifter: formats slots (MSB first, zero padded) and
// shifts one wire bit per BCK; I2S runs one bit late.
module audio_frame_shifter
  import audio_serial_frame_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int SLOT_WIDTH = 32,
  parameter int CHANNELS   = 2
) (
  input  logic                           AUDIO_CLK,
  input  logic                           reset_reg_N,
  input  logic                           load_i,
  input  logic                           keep_i,
  input  logic                           adv_i,
  input  logic [CHANNELS*DATA_WIDTH-1:0] frame_i,
  input  logic [1:0]                     mode_i,
  output logic                           sdata_o
);

  localparam int FB = SLOT_WIDTH * CHANNELS;

  logic [FB-1:0] fmt;
  logic [FB-1:0] sr_q, sr_d;
  logic          prev_q, prev_d;

  always_comb begin
    fmt = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      fmt[(CHANNELS-1-n)*SLOT_WIDTH +: SLOT_WIDTH] =
        SLOT_WIDTH'(frame_i[n*DATA_WIDTH +: DATA_WIDTH])
          << (SLOT_WIDTH - DATA_WIDTH);
    end
  end

  // On a back-to-back I2S load the old frame's last bit spills into bit 0
  always_comb begin
    sr_d   = sr_q;
    prev_d = prev_q;
    if (load_i) begin
      sr_d   = fmt;
      prev_d = keep_i && (mode_i == FMT_I2S) && sr_q[FB-1];
    end else if (adv_i) begin
      sr_d   = {sr_q[FB-2:0], 1'b0};
      prev_d = sr_q[FB-1];
    end
  end

  always_ff @(posedge AUDIO_CLK or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      sr_q   <= '0;
      prev_q <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      prev_q <= prev_d;
    end
  end

  assign sdata_o = (mode_i == FMT_I2S) ? prev_q : sr_q[FB-1];

endmodule

// File: rtl/audio_serial_frame_gen.sv
// Audio serial-port generator: BCK/LRCK division, frame FSM,
// one-entry sample hold register and slot decode.
module audio_serial_frame_gen
  import audio_serial_frame_gen_pkg::*;
#(
  parameter int OVERSAMPLING = 384,
  parameter int DATA_WIDTH   = 24,
  parameter int SLOT_WIDTH   = 32,
  parameter int CHANNELS     = 2
) (
  input  logic                           AUDIO_CLK,
  input  logic                           reset_reg_N,
  input  logic                           en,
  input  logic [1:0]                     mode,
  input  logic [CHANNELS*DATA_WIDTH-1:0] frame_data,
  input  logic                           frame_valid,
  output logic                           frame_ready,
  output logic                           oAUD_BCK,
  output logic                           LRCK,
  output logic                           sdata,
  output logic                           frame_tick,
  output logic [$clog2(CHANNELS)-1:0]    slot_idx,
  output logic                           underrun,
  output logic                           busy
);

  localparam int BCK_HALF =
    bck_half(OVERSAMPLING, SLOT_WIDTH, CHANNELS);
  localparam int FBITS  = frame_bits(SLOT_WIDTH, CHANNELS);
  localparam int PH_W   = clog2_min1(2 * BCK_HALF);
  localparam int BIT_W  = $clog2(FBITS);
  localparam int SLOT_W = $clog2(CHANNELS);
  localparam int FW     = CHANNELS * DATA_WIDTH;

  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(2 * BCK_HALF - 1);
  localparam logic [PH_W-1:0]  PH_HALF  = PH_W'(BCK_HALF);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FBITS - 1);
  localparam logic [BIT_W-1:0] BIT_MID  = BIT_W'(FBITS / 2);
  localparam logic [BIT_W-1:0] SW_B     = BIT_W'(SLOT_WIDTH);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  if ((OVERSAMPLING % (2 * SLOT_WIDTH * CHANNELS)) != 0 ||
      BCK_HALF < 1 || DATA_WIDTH > SLOT_WIDTH ||
      CHANNELS < 2 || (CHANNELS % 2) != 0) begin : g_cfg_err
    $error("audio_serial_frame_gen: illegal parameters");
  end

  logic              state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic              full_q, full_d;
  logic [FW-1:0]     hold_q, hold_d;
  logic [1:0]        mode_q, mode_d;
  logic              tick_q, und_q;
  logic              bck_q, bck_d;
  logic              lrck_q, lrck_d;

  logic          running, frame_end, start, stop, adv, take;
  logic [FW-1:0] load_vec;
  logic          sh_sdata;

  assign running   = (state_q == ST_RUN);
  assign frame_end = running && (phase_q == PH_LAST) &&
                     (bit_q == BIT_LAST);
  assign start     = en && (!running || frame_end);
  assign stop      = frame_end && !en;
  assign adv       = running && (phase_q == PH_LAST) && !frame_end;

  // A boundary drains the hold register first, else bypasses
  assign take     = frame_valid && !full_q && !start;
  assign load_vec = full_q ? hold_q :
                    (frame_valid ? frame_data : '0);
  assign full_d   = start ? 1'b0 : (take ? 1'b1 : full_q);
  assign hold_d   = take ? frame_data : hold_q;
  assign mode_d   = start ? fmt_norm(mode) : mode_q;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    if (start) begin
      state_d = ST_RUN;
      phase_d = '0;
      bit_d   = '0;
    end else if (stop) begin
      state_d = ST_IDLE;
      phase_d = '0;
      bit_d   = '0;
    end else if (running) begin
      phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
      if (adv) bit_d = bit_q + 1'b1;
    end
  end

  always_comb begin
    lrck_d = 1'b0;
    unique case (1'b1)
      mode_d == FMT_TDM: lrck_d = (bit_d == '0);
      mode_d == FMT_LJ:  lrck_d = (bit_d < BIT_MID);
      default:           lrck_d = (bit_d >= BIT_MID);
    endcase
    lrck_d = lrck_d && (state_d == ST_RUN);
  end

  assign bck_d  = (state_d == ST_RUN) && (phase_d >= PH_HALF);
  assign slot_d = SLOT_W'(bit_d / SW_B);

  always_ff @(posedge AUDIO_CLK or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      bit_q   <= '0;
      slot_q  <= '0;
      full_q  <= 1'b0;
      hold_q  <= '0;
      mode_q  <= FMT_I2S;
      tick_q  <= 1'b0;
      und_q   <= 1'b0;
      bck_q   <= 1'b0;
      lrck_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      slot_q  <= slot_d;
      full_q  <= full_d;
      hold_q  <= hold_d;
      mode_q  <= mode_d;
      tick_q  <= start;
      und_q   <= start && !full_q && !frame_valid;
      bck_q   <= bck_d;
      lrck_q  <= lrck_d;
    end
  end

  audio_frame_shifter #(
    .DATA_WIDTH (DATA_WIDTH),
    .SLOT_WIDTH (SLOT_WIDTH),
    .CHANNELS   (CHANNELS)
  ) u_shifter (
    .AUDIO_CLK   (AUDIO_CLK),
    .reset_reg_N (reset_reg_N),
    .load_i      (start),
    .keep_i      (running),
    .adv_i       (adv),
    .frame_i     (load_vec),
    .mode_i      (mode_q),
    .sdata_o     (sh_sdata)
  );

  assign frame_ready = !full_q;
  assign oAUD_BCK    = bck_q;
  assign LRCK        = lrck_q;
  assign sdata       = running && sh_sdata;
  assign frame_tick  = tick_q;
  assign slot_idx    = slot_q;
  assign underrun    = und_q;
  assign busy        = running;

endmodule

// File: tb/tb_audio_serial_frame_gen.sv
// Bench for audio_serial_frame_gen: two configurations driven with
// random frames and checked cycle by cycle against a frame model.
module tb_audio_serial_frame_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;

  logic [47:0] fd0;
  logic        fv0, rdy0, bck0, lr0, sd0, tick0, und0, busy0;
  logic        slot0;
  logic [63:0] fd1;
  logic        fv1, rdy1, bck1, lr1, sd1, tick1, und1, busy1;
  logic [1:0]  slot1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  audio_serial_frame_gen #(
    .OVERSAMPLING (384),
    .DATA_WIDTH   (24),
    .SLOT_WIDTH   (32),
    .CHANNELS     (2)
  ) dut0 (
    .AUDIO_CLK   (clk),
    .reset_reg_N (rst_n),
    .en          (en),
    .mode        (mode),
    .frame_data  (fd0),
    .frame_valid (fv0),
    .frame_ready (rdy0),
    .oAUD_BCK    (bck0),
    .LRCK        (lr0),
    .sdata       (sd0),
    .frame_tick  (tick0),
    .slot_idx    (slot0),
    .underrun    (und0),
    .busy        (busy0)
  );

  audio_serial_frame_gen #(
    .OVERSAMPLING (128),
    .DATA_WIDTH   (16),
    .SLOT_WIDTH   (16),
    .CHANNELS     (4)
  ) dut1 (
    .AUDIO_CLK   (clk),
    .reset_reg_N (rst_n),
    .en          (en),
    .mode        (mode),
    .frame_data  (fd1),
    .frame_valid (fv1),
    .frame_ready (rdy1),
    .oAUD_BCK    (bck1),
    .LRCK        (lr1),
    .sdata       (sd1),
    .frame_tick  (tick1),
    .slot_idx    (slot1),
    .underrun    (und1),
    .busy        (busy1)
  );

  function automatic int os_of(int i);
    return (i == 0) ? 384 : 128;
  endfunction
  function automatic int ch_of(int i);
    return (i == 0) ? 2 : 4;
  endfunction
  function automatic int sw_of(int i);
    return (i == 0) ? 32 : 16;
  endfunction
  function automatic int dw_of(int i);
    return (i == 0) ? 24 : 16;
  endfunction
  function automatic int fb_of(int i);
    return sw_of(i) * ch_of(i);
  endfunction
  function automatic int bh_of(int i);
    return os_of(i) / (2 * fb_of(i));
  endfunction

  bit          m_run   [2];
  int          m_t     [2];
  bit          m_full  [2];
  logic [63:0] m_hold  [2];
  logic [63:0] m_frame [2];
  logic [1:0]  m_mode  [2];
  bit          m_tick  [2];
  bit          m_und   [2];
  bit          m_spill [2];

  // Wire bit k of a frame with the MSB of slot n at bit n*SLOT_WIDTH
  function automatic logic lj_bit(int i, logic [63:0] fr, int k);
    int n, j;
    n = k / sw_of(i);
    j = k % sw_of(i);
    if (j >= dw_of(i)) return 1'b0;
    return fr[n*dw_of(i) + dw_of(i) - 1 - j];
  endfunction

  function automatic logic wire_bit(int i, int k);
    if (m_mode[i] == 2'd0) begin
      if (k == 0) return m_spill[i];
      return lj_bit(i, m_frame[i], k - 1);
    end
    return lj_bit(i, m_frame[i], k);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_run[i]   = 0;
      m_t[i]     = 0;
      m_full[i]  = 0;
      m_hold[i]  = '0;
      m_frame[i] = '0;
      m_mode[i]  = 2'd0;
      m_tick[i]  = 0;
      m_und[i]   = 0;
      m_spill[i] = 0;
    end
  endtask

  task automatic model_step(int i, logic v, logic [63:0] d);
    bit last, bnd, stp;
    last = m_run[i] && (m_t[i] == os_of(i) - 1);
    bnd  = en && (!m_run[i] || last);
    stp  = last && !en;
    m_tick[i] = bnd;
    m_und[i]  = 0;
    if (bnd) begin
      m_spill[i] = (m_run[i] && m_mode[i] == 2'd0) ?
                   lj_bit(i, m_frame[i], fb_of(i) - 1) : 1'b0;
      if (m_full[i]) begin
        m_frame[i] = m_hold[i];
        m_full[i]  = 0;
      end else if (v) begin
        m_frame[i] = d;
      end else begin
        m_frame[i] = '0;
        m_und[i]   = 1;
      end
      m_mode[i] = (mode == 2'd3) ? 2'd0 : mode;
      m_run[i]  = 1;
      m_t[i]    = 0;
    end else begin
      if (!m_full[i] && v) begin
        m_hold[i] = d;
        m_full[i] = 1;
      end
      if (stp) begin
        m_run[i] = 0;
        m_t[i]   = 0;
      end else if (m_run[i]) begin
        m_t[i]++;
      end
    end
  endtask

  function automatic logic [8:0] exp_out(int i);
    int ph, b, s;
    logic bk, lr, sd;
    logic [1:0] sl;
    bk = 0; lr = 0; sd = 0; sl = '0;
    if (m_run[i]) begin
      ph = m_t[i] % (2 * bh_of(i));
      b  = m_t[i] / (2 * bh_of(i));
      s  = b / sw_of(i);
      bk = (ph >= bh_of(i));
      case (m_mode[i])
        2'd2:    lr = (b == 0);
        2'd1:    lr = (s < ch_of(i) / 2);
        default: lr = (s >= ch_of(i) / 2);
      endcase
      sd = wire_bit(i, b);
      sl = 2'(s);
    end
    return {m_run[i], !m_full[i], m_tick[i], m_und[i],
            bk, lr, sd, sl};
  endfunction

  function automatic logic [8:0] obs0();
    return {busy0, rdy0, tick0, und0, bck0, lr0, sd0, 1'b0, slot0};
  endfunction
  function automatic logic [8:0] obs1();
    return {busy1, rdy1, tick1, und1, bck1, lr1, sd1, slot1};
  endfunction

  task automatic chk(string tag, logic [8:0] got, logic [8:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %b exp %b", tag, $time, got, exp);
    end
  endtask

  task automatic step(string tag);
    model_step(0, fv0, 64'(fd0));
    model_step(1, fv1, fd1);
    @(posedge clk);
    #1;
    chk({tag, "/d0"}, obs0(), exp_out(0));
    chk({tag, "/d1"}, obs1(), exp_out(1));
  endtask

  task automatic rnd_data();
    fd0 = {$urandom, $urandom};
    fd1 = {$urandom, $urandom};
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    mode  = 2'd0;
    fd0   = '0;
    fd1   = '0;
    fv0   = 1'b0;
    fv1   = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("in_reset/d0", obs0(), 9'h080);
    chk("in_reset/d1", obs1(), 9'h080);
    rst_n = 1'b1;
    repeat (2) step("idle");

    // I2S with fixed frames, continuous supply
    fd0  = {24'h800001, 24'hA5A5A5};
    fd1  = 64'h8001_1234_A5A5_FFFF;
    fv0  = 1'b1;
    fv1  = 1'b1;
    en   = 1'b1;
    repeat (3 * 384) step("i2s");

    mode = 2'd1;
    repeat (2 * 384) begin
      rnd_data();
      step("lj");
    end

    mode = 2'd2;
    repeat (2 * 384) begin
      rnd_data();
      step("tdm");
    end

    mode = 2'd3;
    repeat (2 * 384) begin
      rnd_data();
      step("rsvd");
    end

    mode = 2'd0;
    fv0  = 1'b0;
    fv1  = 1'b0;
    repeat (3 * 384) step("underrun");

    // Offer a frame only on the boundary cycle itself
    repeat (2 * 384) begin
      rnd_data();
      fv0 = m_run[0] && (m_t[0] == os_of(0) - 1);
      fv1 = m_run[1] && (m_t[1] == os_of(1) - 1);
      step("bypass");
    end

    fv0 = 1'b1;
    fv1 = 1'b1;
    for (int k = 0; k < 400 && m_t[0] != 60; k++) step("pre_stop");
    en = 1'b0;
    repeat (400) begin
      rnd_data();
      step("stop");
    end
    en = 1'b1;
    repeat (800) begin
      rnd_data();
      step("restart");
    end

    for (int k = 0; k < 10000; k++) begin
      rnd_data();
      fv0 = ($urandom_range(3) == 0);
      fv1 = ($urandom_range(3) == 0);
      if ($urandom_range(199) == 0) mode = 2'($urandom_range(3));
      if ($urandom_range(1499) == 0) en = ~en;
      step("random");
    end

    // Asynchronous reset in the middle of dut0 bit 40
    en   = 1'b1;
    fv0  = 1'b1;
    fv1  = 1'b1;
    mode = 2'd0;
    for (int k = 0; k < 800 && !(m_run[0] && m_t[0] == 240); k++)
      step("pre_arst");
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst/d0", obs0(), 9'h080);
    chk("arst/d1", obs1(), 9'h080);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2 * 384) begin
      rnd_data();
      step("post_arst");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
